// File: rtl/match_event_logger.sv
// Turns each high interval of the pattern detector's match level into an event.
// Counts events, times each interval and offers one duration record per event on a valid/ready port.
module match_event_logger #(
    parameter int CNT_W = 8,
    parameter int DUR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             match_i,
    input  logic             clear,
    output logic [CNT_W-1:0] evt_count,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [DUR_W-1:0] rec_dur,
    output logic             rec_ovf,
    output logic             drop
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};

    state_t           state_reg;
    logic             match_q;
    logic [DUR_W-1:0] dur_reg;
    logic             ovf_acc_reg;
    logic             rise;
    logic             slot_free;

    assign rise      = match_i & ~match_q;
    // A record being handed over this cycle frees the slot for a new one.
    assign slot_free = ~rec_valid | rec_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            match_q     <= 1'b0;
            dur_reg     <= '0;
            ovf_acc_reg <= 1'b0;
            evt_count   <= '0;
            rec_valid   <= 1'b0;
            rec_dur     <= '0;
            rec_ovf     <= 1'b0;
            drop        <= 1'b0;
        end else begin
            // Edge history keeps tracking during clear, so a level already high is not counted.
            match_q <= match_i;
            if (clear) begin
                state_reg   <= IDLE;
                dur_reg     <= '0;
                ovf_acc_reg <= 1'b0;
                evt_count   <= '0;
                drop        <= 1'b0;
                rec_valid   <= 1'b0;
            end else begin
                if (rec_valid && rec_ready) begin
                    rec_valid <= 1'b0;
                end
                case (state_reg)
                    IDLE: begin
                        if (rise) begin
                            state_reg   <= RUN;
                            dur_reg     <= {{(DUR_W-1){1'b0}}, 1'b1};
                            ovf_acc_reg <= 1'b0;
                            if (evt_count != CNT_MAX) begin
                                evt_count <= evt_count + 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (match_i) begin
                            if (dur_reg == DUR_MAX) begin
                                ovf_acc_reg <= 1'b1;
                            end else begin
                                dur_reg <= dur_reg + 1'b1;
                            end
                        end else begin
                            state_reg <= IDLE;
                            if (slot_free) begin
                                rec_valid <= 1'b1;
                                rec_dur   <= dur_reg;
                                rec_ovf   <= ovf_acc_reg;
                            end else begin
                                drop <= 1'b1;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/match_event_logger.md
Name: match_event_logger

Overview:
- Downstream consumer of the run-pattern detector's level output (asserted while a run of identical input bits is being matched).
- Converts each match interval into an event: counts events, measures each interval's length in clock cycles, and hands one duration record per event to a consumer over a valid/ready interface.
- Flags records lost to back-pressure.

Parameters:
- CNT_W, 8, width of the saturating event counter.
- DUR_W, 8, width of the saturating per-event duration counter and record.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- match_i  in  1  match level from the pattern detector.
- clear  in  1  synchronous clear of counters, flags and pending record.
- evt_count  out  CNT_W  number of match events seen, saturating.
- rec_valid  out  1  duration record available.
- rec_ready  in  1  consumer accepts record when rec_valid=1 and rec_ready=1.
- rec_dur  out  DUR_W  cycles match_i was high for the reported event.
- rec_ovf  out  1  event duration exceeded 2^DUR_W-1 and was clipped.
- drop  out  1  sticky: at least one record was discarded because the slot was occupied.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, match_q=0, duration counter=0, evt_count=0, rec_valid=0, rec_dur=0, rec_ovf=0, drop=0. All outputs are 0 while reset=0.
- match_q is a registered copy of match_i.
- Rising edge means match_i=1 and match_q=0. Falling edge means state RUN and match_i=0.
- States:
  - IDLE: on rising edge -> RUN; duration counter=1, ovf_acc=0; evt_count += 1, saturating at 2^CNT_W-1. Otherwise stay.
  - RUN, match_i=1: duration counter += 1. If already 2^DUR_W-1, hold the value and set ovf_acc=1. Stay in RUN.
  - RUN, match_i=0: finalize the record -> IDLE.
- Finalize:
  - Record slot is free when rec_valid=0, or when rec_valid=1 and rec_ready=1 in the same cycle.
  - Slot free: next cycle rec_dur=duration counter, rec_ovf=ovf_acc, rec_valid=1.
  - Slot not free: the new record is discarded, the held record is unchanged, and drop=1 next cycle.
- Latency: rec_valid rises on the clock edge after the first cycle with match_i=0. A 1-cycle match gives rec_dur=1.
- Handshake:
  - rec_valid, rec_dur and rec_ovf stay stable while rec_valid=1 and rec_ready=0.
  - rec_valid=1 and rec_ready=1 with no finalize in that cycle: rec_valid=0 next cycle.
  - rec_valid=1 and rec_ready=1 with a finalize in the same cycle: the new record is loaded, rec_valid stays 1, no drop.
  - rec_ready while rec_valid=0 is ignored.
- Back-to-back events: falling edge then match_i=1 on the next cycle is a new rising edge (match_q=0) and counts as a new event.
- clear=1 (synchronous, priority over all other updates):
  - state=IDLE, duration counter=0, evt_count=0, drop=0, rec_valid=0.
  - rec_dur and rec_ovf are not cleared.
  - match_q still samples match_i. A match already high during clear is not counted; the next rising edge after clear is.
- match_i=1 on the first cycle after reset release is counted as a rising edge.
- Async reset during RUN discards the in-progress event with no record.
- Saturation is silent for evt_count. For duration, saturation is reported through rec_ovf.

Test Plan:
- Defaults, rec_ready=1; match_i high 5 cycles then low -> evt_count=1; rec_valid high exactly 1 cycle, rising 1 edge after match_i falls; rec_dur=5, rec_ovf=0, drop=0.
- match_i high 300 cycles -> rec_dur=255, rec_ovf=1, evt_count=1.
- rec_ready=0; runs of 3 cycles and 4 cycles separated by 2 low cycles -> evt_count=2; rec_dur holds 3 with rec_valid=1; drop=1. Then rec_ready=1 for one cycle -> record 3 consumed, rec_valid=0.
- rec_ready=0; first run of 2 cycles pending. rec_ready=1 exactly in the finalize cycle of a 7-cycle run -> record 2 accepted; next cycle rec_dur=7, rec_valid stays 1, drop=0.
- 260 one-cycle runs separated by one low cycle, rec_ready=1 -> evt_count=255 (saturated), 260 records each with rec_dur=1.
- reset=0 pulsed mid-run (no clock edge) -> all outputs 0 immediately, no record after release. clear=1 for one cycle while match_i=1, hold match_i=1 for 4 cycles -> evt_count stays 0, no record.
